// File: rtl/fft_frame_buffer_if.sv
// Stream-in / frame-out bus for fft_frame_buffer.
//   s_valid/s_ready/s_data/s_last : one complex sample per cycle into the buffer
//   m_valid/m_ready/m_frame       : one packed N-sample frame out of the buffer
//   short_frame                   : one-cycle pulse after a frame was closed early
// master = producer/consumer side, slave = buffer side.
interface fft_frame_buffer_if #(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16
);
  logic                        s_valid;
  logic                        s_ready;
  logic [SAMPLE_WIDTH-1:0]     s_data;
  logic                        s_last;
  logic                        m_valid;
  logic                        m_ready;
  logic [N*SAMPLE_WIDTH-1:0]   m_frame;
  logic                        short_frame;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_frame, short_frame
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_frame, short_frame
  );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong input framer for fft_np.
// Collects complex samples into N-sample frames in two banks and presents each
// completed frame as one packed word (slot i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]).
// Frames closed early by s_last are zero-padded and flagged with short_frame.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : fft_frame_buffer_if.slave (sample stream in, frame out)
module fft_frame_buffer #(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BITREV       = 0
) (
  input  logic                clk,
  input  logic                arst_n,
  fft_frame_buffer_if.slave   bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [SAMPLE_WIDTH-1:0] bank_q [2][N];
  logic [SAMPLE_WIDTH-1:0] bank_d [2][N];
  logic [AW-1:0]           wr_idx_q, wr_idx_d;
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    short_q, short_d;

  logic                    wr_fire;
  logic                    rd_fire;
  logic                    at_end;

  // Frame slot for a given arrival index.
  function automatic logic [AW-1:0] slot_of(input logic [AW-1:0] idx);
    logic [AW-1:0] r;
    r = idx;
    if (BITREV != 0) begin
      for (int unsigned b = 0; b < AW; b++) r[b] = idx[AW-1-b];
    end
    return r;
  endfunction

  assign bus.s_ready     = !full_q[wr_bank_q];
  assign bus.m_valid     = full_q[rd_bank_q];
  assign bus.short_frame = short_q;

  always_comb begin
    bus.m_frame = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.m_frame[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bank_q[rd_bank_q][i];
    end
  end

  always_comb begin
    bank_d    = bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    short_d   = 1'b0;

    wr_fire = bus.s_valid && !full_q[wr_bank_q];
    rd_fire = full_q[rd_bank_q] && bus.m_ready;
    at_end  = (wr_idx_q == AW'(N-1));

    // A write needs wr_bank empty and a read needs rd_bank full, so in the
    // same cycle they always touch different banks.
    if (rd_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (wr_fire) begin
      bank_d[wr_bank_q][slot_of(wr_idx_q)] = bus.s_data;
      if (at_end || bus.s_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
        if (!at_end) begin
          short_d = 1'b1;
          for (int unsigned j = 0; j < N; j++) begin
            if (AW'(j) > wr_idx_q) bank_d[wr_bank_q][slot_of(AW'(j))] = '0;
          end
        end
      end else begin
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < N; i++) bank_q[b][i] <= '0;
      end
      wr_idx_q  <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      short_q   <= short_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;
  logic clk;
  logic arst_n;
  int   total;
  int   bad;

  fft_frame_buffer_if #(.N(4), .SAMPLE_WIDTH(16)) if0 ();
  fft_frame_buffer_if #(.N(4), .SAMPLE_WIDTH(16)) if1 ();

  fft_frame_buffer #(.N(4), .SAMPLE_WIDTH(16), .BITREV(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .bus(if0.slave));
  fft_frame_buffer #(.N(4), .SAMPLE_WIDTH(16), .BITREV(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic mr);
    if0.s_valid = v; if0.s_data = d; if0.s_last = l; if0.m_ready = mr;
    if1.s_valid = v; if1.s_data = d; if1.s_last = l; if1.m_ready = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] smp;
    total = 0;
    bad   = 0;
    arst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step(); step();
    arst_n = 1'b1;
    step();

    // reset state
    check("rst_m_valid", 64'(if0.m_valid), 64'd0);
    check("rst_m_frame", if0.m_frame, 64'd0);
    check("rst_s_ready", 64'(if0.s_ready), 64'd1);
    check("rst_short",   64'(if0.short_frame), 64'd0);

    // natural and bit-reversed order, m_ready high
    for (int i = 0; i < 4; i++) begin
      smp = 16'(16'h0010 * (i + 1));
      drive(1'b1, smp, 1'b0, 1'b1);
      check("t1_s_ready", 64'(if0.s_ready), 64'd1);
      check("t1_m_valid_pre", 64'(if0.m_valid), 64'd0);
      step();
    end
    check("t1_m_valid", 64'(if0.m_valid), 64'd1);
    check("t1_frame", if0.m_frame, 64'h0040_0030_0020_0010);
    check("t2_bitrev_frame", if1.m_frame, 64'h0040_0020_0030_0010);
    check("t1_s_ready_end", 64'(if0.s_ready), 64'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    check("t1_m_valid_one_cycle", 64'(if0.m_valid), 64'd0);

    // both banks fill with m_ready low
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      check("t3_s_ready_fill", 64'(if0.s_ready), 64'd1);
      step();
    end
    check("t3_s_ready_full", 64'(if0.s_ready), 64'd0);
    check("t3_m_valid_full", 64'(if0.m_valid), 64'd1);
    check("t3_frame_a", if0.m_frame, 64'h0004_0003_0002_0001);
    drive(1'b1, 16'd9, 1'b0, 1'b0);
    step(); step();
    check("t3_s_ready_hold", 64'(if0.s_ready), 64'd0);
    check("t3_frame_stable", if0.m_frame, 64'h0004_0003_0002_0001);
    drive(1'b1, 16'd9, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'd9, 1'b0, 1'b0);
    check("t3_s_ready_rise", 64'(if0.s_ready), 64'd1);
    check("t3_m_valid_b", 64'(if0.m_valid), 64'd1);
    check("t3_frame_b", if0.m_frame, 64'h0008_0007_0006_0005);
    step();
    for (int i = 10; i <= 12; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      check("t3_s_ready_refill", 64'(if0.s_ready), 64'd1);
      step();
    end
    check("t3_s_ready_full2", 64'(if0.s_ready), 64'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    check("t3_m_valid_c", 64'(if0.m_valid), 64'd1);
    check("t3_frame_c", if0.m_frame, 64'h000c_000b_000a_0009);
    step();
    check("t3_drained", 64'(if0.m_valid), 64'd0);

    // short frame closed by s_last
    drive(1'b1, 16'h0101, 1'b0, 1'b1);
    step();
    check("t4_short_pre", 64'(if0.short_frame), 64'd0);
    drive(1'b1, 16'h0202, 1'b1, 1'b1);
    step();
    check("t4_m_valid", 64'(if0.m_valid), 64'd1);
    check("t4_frame", if0.m_frame, 64'h0000_0000_0202_0101);
    check("t4_bitrev_pad", if1.m_frame, 64'h0000_0202_0000_0101);
    check("t4_short", 64'(if0.short_frame), 64'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    check("t4_short_once", 64'(if0.short_frame), 64'd0);
    check("t4_m_valid_off", 64'(if0.m_valid), 64'd0);
    // next frame from slot 0, with a mid-frame stall and s_last on slot N-1
    drive(1'b1, 16'h1111, 1'b0, 1'b1); step();
    drive(1'b1, 16'h2222, 1'b0, 1'b1); step();
    drive(1'b0, 16'hdead, 1'b0, 1'b1); step(); step();
    check("t4_stall_m_valid", 64'(if0.m_valid), 64'd0);
    drive(1'b1, 16'h3333, 1'b0, 1'b1); step();
    check("t4_m_valid_early", 64'(if0.m_valid), 64'd0);
    drive(1'b1, 16'h4444, 1'b1, 1'b1); step();
    check("t4_full_frame", if0.m_frame, 64'h4444_3333_2222_1111);
    check("t4_full_valid", 64'(if0.m_valid), 64'd1);
    check("t4_last_at_end_no_pulse", 64'(if0.short_frame), 64'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step();

    // reset mid-frame
    drive(1'b1, 16'haaaa, 1'b0, 1'b1); step();
    drive(1'b1, 16'hbbbb, 1'b0, 1'b1); step();
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    arst_n = 1'b0;
    #1;
    check("t5_rst_m_valid", 64'(if0.m_valid), 64'd0);
    check("t5_rst_s_ready", 64'(if0.s_ready), 64'd1);
    step();
    arst_n = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(16'hc000 + i), 1'b0, 1'b1);
      step();
      if (i < 4) check("t5_no_stale_frame", 64'(if0.m_valid), 64'd0);
    end
    check("t5_m_valid", 64'(if0.m_valid), 64'd1);
    check("t5_frame", if0.m_frame, 64'hc004_c003_c002_c001);

    // 16 samples back-to-back, m_ready high
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(16'h1000 + i), 1'b0, 1'b1);
      check("t6_s_ready", 64'(if0.s_ready), 64'd1);
      step();
      check("t6_m_valid", 64'(if0.m_valid), ((i % 4) == 3) ? 64'd1 : 64'd0);
      if ((i % 4) == 3) begin
        check("t6_frame", if0.m_frame,
              {16'(16'h1000 + i), 16'(16'h1000 + i - 1),
               16'(16'h1000 + i - 2), 16'(16'h1000 + i - 3)});
      end
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    check("t6_end_m_valid", 64'(if0.m_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Input framer that sits directly upstream of fft_np.
- Accepts a stream of complex samples, one per cycle, over a valid/ready handshake.
- Assembles them into N-sample frames in a ping-pong pair of banks.
- Presents each completed frame as one packed word matching fft_np's data_in, with an optional bit-reversed ordering and zero-padding of short frames.

Parameters:
- N, 4, frame length in complex samples; power of two, >= 2.
- SAMPLE_WIDTH, 16, bits per complex sample: real in [SAMPLE_WIDTH/2-1:0], imag in [SAMPLE_WIDTH-1:SAMPLE_WIDTH/2], each two's complement.
- BITREV, 0, 1 = frame slot i carries the sample with arrival index bitrev(i) over log2(N) bits; 0 = natural order.

Ports:
- clk  input  1  clock; all state on the rising edge.
- arst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  buffer can accept a sample this cycle.
- s_data  input  SAMPLE_WIDTH  input complex sample.
- s_last  input  1  marks the final sample of a frame; only meaningful with s_valid.
- m_valid  output  1  a complete frame is presented on m_frame.
- m_ready  input  1  downstream accepts the frame this cycle.
- m_frame  output  N*SAMPLE_WIDTH  packed frame; slot i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH], same packing as fft_np data_in.
- short_frame  output  1  one-cycle pulse when a frame was closed early by s_last and zero-padded.

Behaviour:
- Reset (arst_n low, asynchronous): wr_bank=0, rd_bank=0, wr_idx=0, bank_full=2'b00, both banks cleared to 0, short_frame=0.
  - Consequences: m_valid=0, m_frame=0, s_ready=1 while arst_n is high after reset.
  - Reset mid-frame discards partial and complete frames; no output follows.
- State:
  - Two banks of N samples.
  - wr_idx counter, 0..N-1.
  - bank_full[1:0], wr_bank, rd_bank.
- Write side:
  - s_ready = !bank_full[wr_bank], combinational from registers only (never from s_valid or m_ready).
  - Transfer occurs when s_valid && s_ready. The sample is stored at bank[wr_bank] slot wr_idx, or slot bitrev(wr_idx) when BITREV=1.
  - Frame completes on a transfer with wr_idx==N-1, or on a transfer with s_last=1.
  - On completion: bank_full[wr_bank] is set, wr_bank toggles, wr_idx returns to 0.
  - Otherwise wr_idx increments by 1.
  - s_last at wr_idx==N-1 is a normal frame close with no pulse.
- Zero-pad:
  - On s_last at wr_idx=k<N-1, every slot for arrival indices k+1..N-1 (after BITREV mapping) is written to 0 in the same cycle.
  - short_frame pulses high the following cycle.
- Read side:
  - m_valid = bank_full[rd_bank].
  - m_frame = contents of bank[rd_bank], driven from registers; stable while m_valid && !m_ready.
  - On m_valid && m_ready: bank_full[rd_bank] clears and rd_bank toggles.
- Latency: the closing transfer at edge t gives m_valid=1 after edge t, i.e. visible in the cycle following the last sample.
- Simultaneous events:
  - A frame completing into one bank while the other bank is read out is fully concurrent; both updates take effect on the same edge.
  - With m_ready held high, s_ready never drops: sustained 1 sample/cycle.
- Full: both banks full gives s_ready=0. The first m_ready handshake frees a bank, and s_ready rises the next cycle.
- Empty: m_valid=0; m_ready is ignored.
- Mid-frame input stalls (s_valid low) hold wr_idx and bank contents unchanged.

Test Plan:
- Reset, N=4, BITREV=0, m_ready=1; stream s_data = 16'h0010, 16'h0020, 16'h0030, 16'h0040 on consecutive cycles -> one cycle after the 4th transfer, m_valid=1 and m_frame=64'h0040_0030_0020_0010 for exactly one cycle; s_ready stays 1 throughout.
- BITREV=1, same stream -> m_frame slots 0..3 = 16'h0010, 16'h0030, 16'h0020, 16'h0040.
- m_ready=0, stream 12 samples continuously -> two frames are held, s_ready falls after the 8th transfer. Then pulse m_ready once -> the first frame (samples 1-4) is consumed, s_ready rises the next cycle, and the 9th sample is accepted.
- s_last on the 2nd sample (16'h0101, 16'h0202) -> m_frame = 64'h0000_0000_0202_0101, short_frame pulses once. The next frame starts at wr_idx=0.
- Assert arst_n=0 after 2 of 4 samples, release, stream 4 new samples -> no frame appears before the new frame completes, and the new frame contains only the post-reset samples.
- Back-to-back streaming of 16 samples with m_ready=1 -> 4 frames out in order, each m_valid one cycle, no s_ready deassertion.
